valu_beat_seq: RTL and testbench

// - Per-instruction beat sequencer directly upstream of the vALU index generator (vID) and peer datapath units.
// - Accepts one command (vl, sew, dest beat address), then emits one beat per non-stalled cycle.
// - Each beat carries addr, sew, first element index and tail byte-enable.
// - Beat outputs drive vID in_addr/in_sew/in_start_idx/in_valid; out_byte_en and out_last go to writeback.

---
 rtl/valu_beat_seq_if.sv | 31 +++
 rtl/valu_beat_seq.sv | 137 +++++++++++++
 tb/tb_valu_beat_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/valu_beat_seq_if.sv
// Command and beat bundle between the vALU issue side and valu_beat_seq; master drives commands
// and stall, slave (the sequencer) drives cmd_ready and the registered beat outputs.
interface valu_beat_seq_if #(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int VL_WIDTH          = 12
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [VL_WIDTH-1:0]          cmd_vl;
  logic [2:0]                   cmd_sew;
  logic [REQ_ADDR_WIDTH-1:0]    cmd_addr;
  logic                         in_stall;
  logic                         out_valid;
  logic [REQ_ADDR_WIDTH-1:0]    out_addr;
  logic [2:0]                   out_sew;
  logic [VL_WIDTH-1:0]          out_start_idx;
  logic [REQ_BYTE_EN_WIDTH-1:0] out_byte_en;
  logic                         out_last;
  logic                         out_done;

  modport master (
    output cmd_valid, cmd_vl, cmd_sew, cmd_addr, in_stall,
    input  cmd_ready, out_valid, out_addr, out_sew, out_start_idx, out_byte_en, out_last, out_done
  );

  modport slave (
    input  cmd_valid, cmd_vl, cmd_sew, cmd_addr, in_stall,
    output cmd_ready, out_valid, out_addr, out_sew, out_start_idx, out_byte_en, out_last, out_done
  );
endinterface

// File: rtl/valu_beat_seq.sv
// Beat sequencer: first beat one edge after handshake, then one beat per edge with in_stall low.
// VALU_SEQ_TAIL_MASK_EN defined: last beat byte_en masks unused tail bytes; otherwise all ones.
module valu_beat_seq #(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int VL_WIDTH          = 12
) (
  input  logic            clk,
  input  logic            rst,
  valu_beat_seq_if.slave  bus
);
  localparam int IW = VL_WIDTH + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                        state_q, state_d;
  logic [REQ_ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [VL_WIDTH-1:0]           rem_q, rem_d;
  logic [2:0]                    sew_q, sew_d;
  logic                          valid_q, valid_d;
  logic [REQ_ADDR_WIDTH-1:0]     oaddr_q, oaddr_d;
  logic [2:0]                    osew_q, osew_d;
  logic [VL_WIDTH-1:0]           oidx_q, oidx_d;
  logic [REQ_BYTE_EN_WIDTH-1:0]  be_q, be_d;
  logic                          last_q, last_d;
  logic                          done_q, done_d;

  logic [IW-1:0]                 epb;
  logic                          is_last;
  logic                          cmd_legal;
  logic [REQ_BYTE_EN_WIDTH-1:0]  last_be;

  assign epb       = IW'(REQ_BYTE_EN_WIDTH) >> sew_q;
  assign is_last   = {1'b0, rem_q} <= epb;
  assign cmd_legal = (bus.cmd_sew < 3'd4) && (bus.cmd_vl != '0);

`ifdef VALU_SEQ_TAIL_MASK_EN
  localparam int NBW = VL_WIDTH + 4;
  logic [NBW-1:0] tail_bytes;
  assign tail_bytes = NBW'(rem_q) << sew_q;
  always_comb begin
    last_be = '0;
    for (int b = 0; b < REQ_BYTE_EN_WIDTH; b++) begin
      last_be[b] = NBW'(b) < tail_bytes;
    end
  end
`else
  assign last_be = '1;
`endif

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.out_valid     = valid_q;
  assign bus.out_addr      = oaddr_q;
  assign bus.out_sew       = osew_q;
  assign bus.out_start_idx = oidx_q;
  assign bus.out_byte_en   = be_q;
  assign bus.out_last      = last_q;
  assign bus.out_done      = done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    sew_d   = sew_q;
    valid_d = 1'b0;
    oaddr_d = oaddr_q;
    osew_d  = osew_q;
    oidx_d  = oidx_q;
    be_d    = be_q;
    last_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_legal) begin
            state_d = RUN;
            sew_d   = bus.cmd_sew;
            addr_d  = bus.cmd_addr;
            idx_d   = '0;
            rem_d   = bus.cmd_vl;
          end else begin
            // Empty or illegal command: nothing to issue, report completion immediately.
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!bus.in_stall) begin
          valid_d = 1'b1;
          oaddr_d = addr_q;
          oidx_d  = idx_q[VL_WIDTH-1:0];
          osew_d  = sew_q;
          be_d    = is_last ? last_be : '1;
          last_d  = is_last;
          done_d  = is_last;
          addr_d  = addr_q + REQ_ADDR_WIDTH'(1);
          idx_d   = idx_q + epb;
          rem_d   = is_last ? '0 : rem_q - epb[VL_WIDTH-1:0];
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      sew_q   <= '0;
      valid_q <= 1'b0;
      oaddr_q <= '0;
      osew_q  <= '0;
      oidx_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      sew_q   <= sew_d;
      valid_q <= valid_d;
      oaddr_q <= oaddr_d;
      osew_q  <= osew_d;
      oidx_q  <= oidx_d;
      be_q    <= be_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_valu_beat_seq.sv
// Directed bench for valu_beat_seq; expected byte enables follow VALU_SEQ_TAIL_MASK_EN.
module tb_valu_beat_seq;
  localparam int N = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  valu_beat_seq_if bus ();
  valu_beat_seq dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [11:0] vl;
    logic [2:0]  sew;
    logic [31:0] addr;
  } cmd_t;

  cmd_t cq[$];
  int n_chk = 0;
  int n_fail = 0;

  logic        cap_v[N];
  logic [31:0] cap_addr[N];
  logic [11:0] cap_idx[N];
  logic [7:0]  cap_be[N];
  logic [2:0]  cap_sew[N];
  logic        cap_last[N];
  logic        cap_done[N];
  logic        cap_rdy[N];

  function automatic logic [7:0] tail(input logic [7:0] masked);
`ifdef VALU_SEQ_TAIL_MASK_EN
    return masked;
`else
    return 8'hFF;
`endif
  endfunction

  function automatic int cnt_v();
    int c = 0;
    for (int k = 0; k < N; k++) if (cap_v[k]) c++;
    return c;
  endfunction

  function automatic int cnt_done();
    int c = 0;
    for (int k = 0; k < N; k++) if (cap_done[k]) c++;
    return c;
  endfunction

  task automatic load_next();
    if (cq.size() > 0) begin
      cmd_t c;
      c = cq.pop_front();
      bus.cmd_valid = 1'b1;
      bus.cmd_vl    = c.vl;
      bus.cmd_sew   = c.sew;
      bus.cmd_addr  = c.addr;
    end else begin
      bus.cmd_valid = 1'b0;
    end
  endtask

  // Edge k of the window is recorded at index k; the first queued command meets edge 0.
  task automatic capture(input int stall_edge, input int rst_edge);
    logic hs;
    load_next();
    for (int k = 0; k < N; k++) begin
      bus.in_stall = (k == stall_edge);
      rst = (k == rst_edge);
      hs = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      #1;
      cap_v[k]    = bus.out_valid;
      cap_addr[k] = bus.out_addr;
      cap_idx[k]  = bus.out_start_idx;
      cap_be[k]   = bus.out_byte_en;
      cap_sew[k]  = bus.out_sew;
      cap_last[k] = bus.out_last;
      cap_done[k] = bus.out_done;
      cap_rdy[k]  = bus.cmd_ready;
      if (hs) load_next();
    end
    bus.in_stall = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_vl = '0; bus.cmd_sew = '0; bus.cmd_addr = '0; bus.in_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    n_chk++; if (bus.out_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.out_done); end
    n_chk++; if ({bus.out_addr, bus.out_start_idx, bus.out_byte_en, bus.out_last} !== '0) begin
      n_fail++; $display("FAIL reset_outs got addr %h idx %h be %h last %b exp 0", bus.out_addr, bus.out_start_idx, bus.out_byte_en, bus.out_last);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multibeat();
    logic [31:0] ea[3] = '{32'h100, 32'h101, 32'h102};
    logic [11:0] ei[3] = '{12'd0, 12'd8, 12'd16};
    logic [7:0]  eb[3];
    eb = '{8'hFF, 8'hFF, tail(8'h0F)};
    cq.push_back(cmd_t'{12'd20, 3'd0, 32'h100});
    capture(-1, -1);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (cap_v[i+1] !== 1'b1 || cap_addr[i+1] !== ea[i] || cap_idx[i+1] !== ei[i]) begin
        n_fail++; $display("FAIL mb_beat%0d got v %b addr %h idx %0d exp v 1 addr %h idx %0d", i, cap_v[i+1], cap_addr[i+1], cap_idx[i+1], ea[i], ei[i]);
      end
      n_chk++; if (cap_be[i+1] !== eb[i] || cap_last[i+1] !== (i == 2)) begin
        n_fail++; $display("FAIL mb_be%0d got be %h last %b exp be %h last %b", i, cap_be[i+1], cap_last[i+1], eb[i], (i == 2));
      end
    end
    n_chk++; if (cap_done[3] !== 1'b1 || cnt_done() !== 1) begin n_fail++; $display("FAIL mb_done got %b/%0d exp 1/1", cap_done[3], cnt_done()); end
    n_chk++; if (cnt_v() !== 3) begin n_fail++; $display("FAIL mb_count got %0d exp 3", cnt_v()); end
  endtask

  task automatic test_sew32();
    logic [11:0] ei[3] = '{12'd0, 12'd2, 12'd4};
    logic [7:0]  eb[3];
    eb = '{8'hFF, 8'hFF, tail(8'h0F)};
    cq.push_back(cmd_t'{12'd5, 3'd2, 32'h80});
    capture(-1, -1);
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (cap_v[i+1] !== 1'b1 || cap_idx[i+1] !== ei[i] || cap_be[i+1] !== eb[i] || cap_sew[i+1] !== 3'd2) begin
        n_fail++; $display("FAIL sew32_beat%0d got v %b idx %0d be %h sew %0d exp idx %0d be %h sew 2", i, cap_v[i+1], cap_idx[i+1], cap_be[i+1], cap_sew[i+1], ei[i], eb[i]);
      end
    end
    n_chk++; if (cnt_v() !== 3 || cap_last[3] !== 1'b1) begin n_fail++; $display("FAIL sew32_count got %0d last %b exp 3 last 1", cnt_v(), cap_last[3]); end
  endtask

  task automatic test_stall();
    int ek[3] = '{1, 3, 4};
    cq.push_back(cmd_t'{12'd3, 3'd3, 32'h40});
    capture(2, -1);
    n_chk++; if (cap_v[2] !== 1'b0) begin n_fail++; $display("FAIL stall_gap got %b exp 0", cap_v[2]); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (cap_v[ek[i]] !== 1'b1 || cap_idx[ek[i]] !== 12'(i) || cap_addr[ek[i]] !== 32'h40 + 32'(i) || cap_be[ek[i]] !== 8'hFF) begin
        n_fail++; $display("FAIL stall_beat%0d got v %b idx %0d addr %h be %h exp idx %0d addr %h be ff", i, cap_v[ek[i]], cap_idx[ek[i]], cap_addr[ek[i]], cap_be[ek[i]], i, 32'h40 + 32'(i));
      end
    end
    n_chk++; if (cnt_v() !== 3 || cap_done[4] !== 1'b1 || cnt_done() !== 1) begin
      n_fail++; $display("FAIL stall_count got beats %0d done %b/%0d exp 3 1/1", cnt_v(), cap_done[4], cnt_done());
    end
  endtask

  task automatic test_zero_beat();
    cq.push_back(cmd_t'{12'd0, 3'd0, 32'h10});
    cq.push_back(cmd_t'{12'd4, 3'd5, 32'h20});
    capture(-1, -1);
    n_chk++; if (cap_done[0] !== 1'b1 || cap_done[1] !== 1'b1 || cap_done[2] !== 1'b0 || cnt_done() !== 2) begin
      n_fail++; $display("FAIL zero_done got %b%b%b/%0d exp 110/2", cap_done[0], cap_done[1], cap_done[2], cnt_done());
    end
    n_chk++; if (cap_rdy[0] !== 1'b1 || cap_rdy[1] !== 1'b1 || cap_rdy[2] !== 1'b1) begin
      n_fail++; $display("FAIL zero_ready got %b%b%b exp 111", cap_rdy[0], cap_rdy[1], cap_rdy[2]);
    end
    n_chk++; if (cnt_v() !== 0) begin n_fail++; $display("FAIL zero_beats got %0d exp 0", cnt_v()); end
  endtask

  task automatic test_mid_reset();
    cq.push_back(cmd_t'{12'd64, 3'd0, 32'h500});
    capture(-1, 4);
    n_chk++; if (cap_v[3] !== 1'b1 || cap_idx[3] !== 12'd16 || cap_addr[3] !== 32'h502) begin
      n_fail++; $display("FAIL rst_pre got v %b idx %0d addr %h exp 1 16 502", cap_v[3], cap_idx[3], cap_addr[3]);
    end
    n_chk++; if (cap_v[4] !== 1'b0 || cap_addr[4] !== '0 || cap_idx[4] !== '0 || cap_be[4] !== '0 || cap_sew[4] !== '0 || cap_last[4] !== 1'b0) begin
      n_fail++; $display("FAIL rst_outs got v %b addr %h idx %0d be %h exp all 0", cap_v[4], cap_addr[4], cap_idx[4], cap_be[4]);
    end
    n_chk++; if (cap_rdy[4] !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", cap_rdy[4]); end
    n_chk++; if (cnt_done() !== 0 || cnt_v() !== 3) begin n_fail++; $display("FAIL rst_abandon got done %0d beats %0d exp 0 3", cnt_done(), cnt_v()); end
    cq.push_back(cmd_t'{12'd9, 3'd0, 32'h40});
    capture(-1, -1);
    n_chk++; if (cap_v[1] !== 1'b1 || cap_idx[1] !== 12'd0 || cap_addr[1] !== 32'h40) begin
      n_fail++; $display("FAIL rst_restart got v %b idx %0d addr %h exp 1 0 40", cap_v[1], cap_idx[1], cap_addr[1]);
    end
    n_chk++; if (cap_idx[2] !== 12'd8 || cap_be[2] !== tail(8'h01) || cap_done[2] !== 1'b1) begin
      n_fail++; $display("FAIL rst_restart2 got idx %0d be %h done %b exp 8 %h 1", cap_idx[2], cap_be[2], cap_done[2], tail(8'h01));
    end
  endtask

  task automatic test_back_to_back();
    cq.push_back(cmd_t'{12'd8, 3'd0, 32'h200});
    cq.push_back(cmd_t'{12'd3, 3'd1, 32'h300});
    capture(-1, -1);
    n_chk++; if (cap_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b exp 0", cap_rdy[0]); end
    n_chk++; if (cap_v[1] !== 1'b1 || cap_addr[1] !== 32'h200 || cap_last[1] !== 1'b1 || cap_be[1] !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_a got v %b addr %h last %b be %h exp 1 200 1 ff", cap_v[1], cap_addr[1], cap_last[1], cap_be[1]);
    end
    n_chk++; if (cap_rdy[1] !== 1'b1 || cap_rdy[2] !== 1'b0 || cap_v[2] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_bubble got rdy %b%b v %b exp 10 0", cap_rdy[1], cap_rdy[2], cap_v[2]);
    end
    n_chk++; if (cap_v[3] !== 1'b1 || cap_addr[3] !== 32'h300 || cap_idx[3] !== 12'd0 || cap_sew[3] !== 3'd1 || cap_be[3] !== tail(8'h3F)) begin
      n_fail++; $display("FAIL b2b_b got v %b addr %h idx %0d sew %0d be %h exp 1 300 0 1 %h", cap_v[3], cap_addr[3], cap_idx[3], cap_sew[3], cap_be[3], tail(8'h3F));
    end
    n_chk++; if (cnt_v() !== 2 || cnt_done() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d/%0d exp 2/2", cnt_v(), cnt_done()); end
  endtask

  task automatic test_addr_wrap();
    cq.push_back(cmd_t'{12'd2, 3'd3, 32'hFFFF_FFFF});
    capture(-1, -1);
    n_chk++; if (cap_addr[1] !== 32'hFFFF_FFFF || cap_addr[2] !== 32'h0 || cap_idx[2] !== 12'd1 || cap_v[2] !== 1'b1) begin
      n_fail++; $display("FAIL wrap got %h %h idx %0d exp ffffffff 00000000 idx 1", cap_addr[1], cap_addr[2], cap_idx[2]);
    end
  endtask

  initial begin
    test_reset();
    test_multibeat();
    test_sew32();
    test_stall();
    test_zero_beat();
    test_mid_reset();
    test_back_to_back();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
